// File: rtl/fetch_unit_pkg.sv
// Purpose: shared fetch-stage constants and types for the multicycle RV32 core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default reset PC, fetch FSM state encoding, canonical NOP word.
package fetch_unit_pkg;

   // PC loaded on reset unless the instantiating module overrides it.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // addi x0, x0, 0 -- decode substitutes this when it needs a bubble.
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Fetch sequencer states; 2-bit encoding is fixed because other
   // blocks decode it when debugging the core.
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Purpose: program-counter register with load enable and PC+4 adder.
// Latency: load takes effect on the next rising edge; pcadd4 is combinational from pc.
// Backpressure: none; the register simply holds when load_en is low.
// Ports: clk, rst (sync, active-high) | load_en, load_val -> pc, pcadd4.
module fetch_unit_pc_reg #(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic [XLEN-1:0] load_val,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcadd4
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load_en) begin
         pc <= load_val;
      end
   end

   // Wraps modulo 2^XLEN: 0xFFFF_FFFC + 4 -> 0x0000_0000.
   assign pcadd4 = pc + XLEN'(4);

endmodule

// File: rtl/fetch_unit.sv
// Purpose: PC register + instruction-fetch sequencer feeding decode in the multicycle RV32 core.
// Latency: min 3 cycles per instruction (request accepted, response, hold); next request the cycle after ack.
// Backpressure: request address held stable while imem_req_ready is low; instruction held until instr_ack.
// Ports: clk, rst (sync, active-high) | next_pc, instr_ack from core | imem_req_* / imem_rsp_* memory port |
//        pc_out, pcadd4_out to next-PC mux and branch adder | instr_out, instr_valid to decode | misaligned_fault (sticky).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,  // only 32 is supported
   parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] next_pc,
   input  logic            instr_ack,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pcadd4_out,
   output logic [XLEN-1:0] instr_out,
   output logic            instr_valid,
   output logic            misaligned_fault
);

   fetch_state_t state_q;
   fetch_state_t state_d;

   logic pc_load;     // retire: take next_pc
   logic instr_load;  // capture response word
   logic fault_set;   // retire to a non-word-aligned target

   fetch_unit_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .load_en  (pc_load),
      .load_val (next_pc),
      .pc       (pc_out),
      .pcadd4   (pcadd4_out)
   );

   // Request address is the PC itself; it cannot move while in S_REQ
   // because the PC only loads from S_HOLD.
   assign imem_req_addr = pc_out;

   // Gated by rst so nothing leaks out while reset is held, whatever
   // state the register was left in.
   assign imem_req_valid = (state_q == S_REQ)  && !rst;
   assign instr_valid    = (state_q == S_HOLD) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_REQ;
         instr_out        <= '0;
         misaligned_fault <= 1'b0;
      end else begin
         state_q <= state_d;
         if (instr_load) begin
            instr_out <= imem_rsp_data;
         end
         if (fault_set) begin
            misaligned_fault <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_load    = 1'b0;
      instr_load = 1'b0;
      fault_set  = 1'b0;
      unique case (state_q)
         S_REQ: begin
            // Responses are never expected here; a stray one is dropped.
            if (imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               instr_load = 1'b1;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ack) begin
               // PC takes the target even when misaligned so the fault
               // state reports the offending address on pc_out.
               pc_load = 1'b1;
               if (next_pc[1:0] == 2'b00) begin
                  state_d = S_REQ;
               end else begin
                  fault_set = 1'b1;
                  state_d   = S_FAULT;
               end
            end
         end
         S_FAULT: begin
            // Terminal until reset.
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit with a small memory responder and an instruction scoreboard.
// Latency: memory answers one cycle after accepting a request when the responder is enabled.
// Backpressure: imem_req_ready driven directly by the stimulus to stall requests.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] next_pc;
   logic        instr_ack;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pc_out;
   logic [31:0] pcadd4_out;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        misaligned_fault;

   int checks = 0;
   int errors = 0;

   // Scoreboard entries: {expected pc, expected instruction}.
   logic [63:0] exp_q[$];

   logic rsp_en;  // responder owns imem_rsp_* while set

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .next_pc          (next_pc),
      .instr_ack        (instr_ack),
      .imem_req_valid   (imem_req_valid),
      .imem_req_addr    (imem_req_addr),
      .imem_req_ready   (imem_req_ready),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .pc_out           (pc_out),
      .pcadd4_out       (pcadd4_out),
      .instr_out        (instr_out),
      .instr_valid      (instr_valid),
      .misaligned_fault (misaligned_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: mem_word = 32'h0050_0093;
         32'h0000_0010: mem_word = 32'h00A0_0113;
         32'h0000_0100: mem_word = 32'h0000_0013;
         default:       mem_word = {addr[15:0], 16'h0037};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hold(input string name, input int budget);
      int n;
      n = 0;
      while (instr_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, {31'd0, instr_valid}, 32'd1);
   endtask

   // Memory responder: a request accepted at an edge is answered in the
   // following cycle.
   initial begin
      logic        accept;
      logic [31:0] addr;
      forever begin
         @(negedge clk);
         accept = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1) && !rst;
         addr   = imem_req_addr;
         @(posedge clk);
         #1;
         if (rsp_en) begin
            imem_rsp_valid = accept;
            imem_rsp_data  = accept ? mem_word(addr) : 32'h0;
         end
      end
   end

   // Monitor: each new S_HOLD presentation is compared with the oldest
   // expectation.
   initial begin
      logic        prev_v;
      logic [63:0] e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (instr_valid === 1'b1 && !prev_v) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: instr 0x%08h at pc 0x%08h, none expected", instr_out, pc_out);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_out, e[63:32]);
               check("sb_instr", instr_out, e[31:0]);
            end
         end
         prev_v = (instr_valid === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      next_pc        = 32'h0;
      instr_ack      = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      rsp_en         = 1'b1;

      // Reset state.
      tick();
      tick();
      check("rst_pc", pc_out, 32'h0);
      check("rst_instr", instr_out, 32'h0);
      check("rst_fault", {31'd0, misaligned_fault}, 32'd0);
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);

      // First fetch after release.
      rst = 1'b0;
      #1;
      check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t1_req_addr", imem_req_addr, 32'h0);
      check("t1_pcadd4", pcadd4_out, 32'h4);
      exp_q.push_back({32'h0, 32'h0050_0093});
      tick();  // accepted -> WAIT
      check("t1_wait_instr_valid", {31'd0, instr_valid}, 32'd0);
      tick();  // response latched -> HOLD
      check("t1_instr_valid", {31'd0, instr_valid}, 32'd1);
      check("t1_instr", instr_out, 32'h0050_0093);

      // Stalled request at pc 0x10.
      next_pc        = 32'h10;
      instr_ack      = 1'b1;
      imem_req_ready = 1'b0;
      tick();
      instr_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
         check("t2_req_addr", imem_req_addr, 32'h10);
         tick();
      end
      check("t2_still_req", {31'd0, imem_req_valid}, 32'd1);
      imem_req_ready = 1'b1;
      exp_q.push_back({32'h10, 32'h00A0_0113});
      wait_hold("t2_hold", 10);

      // Retire to 0x100.
      next_pc   = 32'h100;
      instr_ack = 1'b1;
      tick();
      check("t3_pc", pc_out, 32'h100);
      check("t3_pcadd4", pcadd4_out, 32'h104);
      check("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t3_instr_valid", {31'd0, instr_valid}, 32'd0);
      exp_q.push_back({32'h100, 32'h0000_0013});

      // Ack held through S_REQ and S_WAIT must not move the PC.
      next_pc   = 32'h200;
      instr_ack = 1'b1;
      tick();  // -> WAIT
      check("t6_pc_in_wait", pc_out, 32'h100);
      tick();  // -> HOLD
      instr_ack = 1'b0;
      check("t6_pc_in_hold", pc_out, 32'h100);
      check("t6_instr_valid", {31'd0, instr_valid}, 32'd1);

      // Retire to the top word: PC+4 wraps.
      next_pc   = 32'hFFFF_FFFC;
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("t5_pc", pc_out, 32'hFFFF_FFFC);
      check("t5_pcadd4", pcadd4_out, 32'h0);
      tick();  // accepted -> WAIT
      check("t5_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
      // Reset while waiting; the response then arrives late.
      rsp_en = 1'b0;
      rst    = 1'b1;
      tick();
      check("t5_rst_pc", pc_out, 32'h0);
      check("t5_rst_instr", instr_out, 32'h0);
      check("t5_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0013;
      #1;
      check("t5_req_valid_after_rst", {31'd0, imem_req_valid}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t5_late_rsp_instr_valid", {31'd0, instr_valid}, 32'd0);
         check("t5_late_rsp_instr", instr_out, 32'h0);
         check("t5_late_rsp_addr", imem_req_addr, 32'h0);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      rsp_en         = 1'b1;
      imem_req_ready = 1'b1;
      exp_q.push_back({32'h0, 32'h0050_0093});
      wait_hold("t5_refetch_hold", 10);

      // Misaligned retire: sticky fault, no further requests.
      next_pc   = 32'h102;
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("t4_fault", {31'd0, misaligned_fault}, 32'd1);
      check("t4_pc", pc_out, 32'h102);
      check("t4_instr_valid", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("t4_no_req", {31'd0, imem_req_valid}, 32'd0);
         check("t4_fault_sticky", {31'd0, misaligned_fault}, 32'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("t4_fault_cleared", {31'd0, misaligned_fault}, 32'd0);
      check("t4_pc_reset", pc_out, 32'h0);
      check("t4_req_after_rst", {31'd0, imem_req_valid}, 32'd1);
      exp_q.push_back({32'h0, 32'h0050_0093});
      wait_hold("t4_refetch_hold", 10);

      // Let the monitor drain the last presentation.
      tick();
      tick();
      check("sb_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
